// File: rtl/tic_tac_toe_engine.sv
// N x N tic-tac-toe engine: board storage, turn/legality checks, per-move line scan.
// Optional macro TTT_SCORE_EN builds saturating per-side win counters.
module tic_tac_toe_engine #(
   parameter int N       = 3,
   parameter int SCORE_W = 8,
   localparam int POS_W  = $clog2(N*N),
   localparam int CNT_W  = $clog2(N*N+1)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               move_valid,
   output logic               move_ready,
   input  logic               move_player,
   input  logic [POS_W-1:0]   move_pos,
   output logic               resp_valid,
   output logic [1:0]         resp_code,
   output logic [2*N*N-1:0]   board,
   output logic               turn,
   output logic               game_over,
   output logic [1:0]         who,
   output logic [CNT_W-1:0]   move_count,
   output logic [SCORE_W-1:0] score_player,
   output logic [SCORE_W-1:0] score_computer
);
   localparam int CELLS = N*N;

   typedef enum logic [2:0] {IDLE, WAIT_MOVE, SCAN, RESP, DONE} state_t;

   state_t           state_q, state_d;
   logic             mover;
   logic [POS_W-1:0] row_q, col_q, k_q;
   logic [POS_W-1:0] mv_row, mv_col;
   logic             row_m, col_m, diag_m, anti_m;
   logic             row_hit, col_hit, diag_hit, anti_hit, win_now;
   logic [1:0]       chk_code, own_mv, own_sc;
   logic             scan_last;

   function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input int idx);
      logic [1:0] c;
      c = 2'b00;
      for (int i = 0; i < CELLS; i++)
         if (i == idx) c = b[2*i +: 2];
      return c;
   endfunction

   assign move_ready = (state_q == WAIT_MOVE);
   assign resp_valid = (state_q == RESP);
   assign own_mv     = move_player ? 2'b10 : 2'b01;
   assign own_sc     = mover ? 2'b10 : 2'b01;
   assign scan_last  = (k_q == POS_W'(N-1));
   assign mv_row     = POS_W'(int'(move_pos) / N);
   assign mv_col     = POS_W'(int'(move_pos) % N);

   // Legality checks in priority order: turn, range, occupancy
   always_comb begin
      chk_code = 2'b00;
      if (move_player != turn)
         chk_code = 2'b11;
      else if (int'(move_pos) >= CELLS)
         chk_code = 2'b10;
      else if (cell_at(board, int'(move_pos)) != 2'b00)
         chk_code = 2'b01;
   end

   // Cell k of each line through the last move; the board already holds that move
   always_comb begin
      row_hit  = cell_at(board, int'(row_q) * N + int'(k_q)) == own_sc;
      col_hit  = cell_at(board, int'(k_q) * N + int'(col_q)) == own_sc;
      diag_hit = cell_at(board, int'(k_q) * N + int'(k_q)) == own_sc;
      anti_hit = cell_at(board, int'(k_q) * N + (N - 1 - int'(k_q))) == own_sc;
      win_now  = (row_m && row_hit) || (col_m && col_hit) ||
                 (diag_m && diag_hit) || (anti_m && anti_hit);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start)
         state_d = WAIT_MOVE;
      else begin
         case (state_q)
            IDLE:      state_d = IDLE;
            WAIT_MOVE: if (move_valid) state_d = (chk_code == 2'b00) ? SCAN : RESP;
            SCAN:      if (scan_last) state_d = RESP;
            RESP:      state_d = game_over ? DONE : WAIT_MOVE;
            DONE:      state_d = DONE;
            default:   state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         board      <= '0;
         turn       <= 1'b0;
         game_over  <= 1'b0;
         who        <= 2'b00;
         move_count <= '0;
         resp_code  <= 2'b00;
         mover      <= 1'b0;
         row_q      <= '0;
         col_q      <= '0;
         k_q        <= '0;
         row_m      <= 1'b0;
         col_m      <= 1'b0;
         diag_m     <= 1'b0;
         anti_m     <= 1'b0;
      end else if (start) begin
         board      <= '0;
         turn       <= 1'b0;
         game_over  <= 1'b0;
         who        <= 2'b00;
         move_count <= '0;
         k_q        <= '0;
      end else begin
         case (state_q)
            WAIT_MOVE: if (move_valid) begin
               resp_code <= chk_code;
               if (chk_code == 2'b00) begin
                  for (int i = 0; i < CELLS; i++)
                     if (i == int'(move_pos)) board[2*i +: 2] <= own_mv;
                  move_count <= move_count + 1'b1;
                  turn       <= ~turn;
                  mover      <= move_player;
                  row_q      <= mv_row;
                  col_q      <= mv_col;
                  k_q        <= '0;
                  row_m      <= 1'b1;
                  col_m      <= 1'b1;
                  diag_m     <= (mv_row == mv_col);
                  anti_m     <= (int'(mv_row) + int'(mv_col) == N - 1);
               end
            end
            SCAN: begin
               row_m  <= row_m && row_hit;
               col_m  <= col_m && col_hit;
               diag_m <= diag_m && diag_hit;
               anti_m <= anti_m && anti_hit;
               k_q    <= k_q + 1'b1;
               if (scan_last) begin
                  if (win_now) begin
                     game_over <= 1'b1;
                     who       <= own_sc;
                  end else if (move_count == CNT_W'(CELLS)) begin
                     game_over <= 1'b1;
                     who       <= 2'b00;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef TTT_SCORE_EN
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Counters survive start; only reset_n clears them
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         score_player   <= '0;
         score_computer <= '0;
      end else if (!start && state_q == SCAN && scan_last && win_now) begin
         if (mover) score_computer <= sat_inc(score_computer);
         else       score_player   <= sat_inc(score_player);
      end
   end
`else
   assign score_player   = '0;
   assign score_computer = '0;
`endif

endmodule
